// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: default geometry and reset constants shared by the fetch front end.
package fetch_prefetch_unit_pkg;
   localparam int DEF_PC_WIDTH    = 13;
   localparam int DEF_INSTR_WIDTH = 32;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_RESET_PC    = 0;
   localparam int DEF_PC_INC      = 1;
endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; head slot stays visible while empty.
module fetch_fifo
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int WIDTH = 45,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   assign rdata = mem[rptr];
   assign valid = count != '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner and 1-cycle-latency imem requester feeding a prefetch FIFO to decode.
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int RESET_PC    = DEF_RESET_PC,
   parameter int PC_INC      = DEF_PC_INC
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          imem_req,
   output logic [PC_WIDTH-1:0]           imem_addr,
   input  logic [INSTR_WIDTH-1:0]        imem_rdata,
   input  logic                          redirect_valid,
   input  logic [PC_WIDTH-1:0]           redirect_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INSTR_WIDTH-1:0]        out_instr,
   output logic [PC_WIDTH-1:0]           out_pc,
   output logic [PC_WIDTH-1:0]           out_pc_next,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [PC_WIDTH-1:0]             pc, req_pc;
   logic                            inflight, kill, push, pop;
   logic [PC_WIDTH+INSTR_WIDTH-1:0] head;
   // Counting the in-flight word reserves its FIFO slot, so a response can never overflow.
   assign imem_req    = !reset && !redirect_valid && ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));
   assign imem_addr   = pc;
   assign push        = inflight && !kill && !redirect_valid;
   assign pop         = out_valid && out_ready && !redirect_valid;
   assign {out_pc, out_instr} = head;
   assign out_pc_next = out_pc + PC_WIDTH'(PC_INC);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc       <= PC_WIDTH'(RESET_PC);
         req_pc   <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
      end else begin
         inflight <= imem_req;
         req_pc   <= pc;
         kill     <= redirect_valid && inflight;
         pc       <= redirect_valid ? redirect_pc : imem_req ? pc + PC_WIDTH'(PC_INC) : pc;
      end
   fetch_fifo #(.WIDTH(PC_WIDTH + INSTR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({req_pc, imem_rdata}),
      .rdata (head),
      .valid (out_valid),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: queue-based fetch model checked every cycle plus hand-computed pins.
module tb_fetch_prefetch_unit;
   logic        clk = 0, reset = 1, redirect_valid = 0, out_ready = 1;
   logic        imem_req, out_valid;
   logic [12:0] imem_addr, out_pc, out_pc_next, redirect_pc = '0;
   logic [31:0] imem_rdata = '0, out_instr;
   logic [2:0]  fifo_count;
   int          total = 0, bad = 0;
   logic [12:0] q[$];
   bit          pend = 0;
   logic [12:0] pend_pc = '0, npc = '0;

   fetch_prefetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= {19'b0, imem_addr} + 32'h100;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: fetched PCs waiting for decode, plus at most one word on its way back from memory.
   task automatic model_edge();
      bit req;
      req = !redirect_valid && (q.size() + int'(pend) < 4);
      if (redirect_valid) begin
         q.delete();
         pend = 0;
         npc  = redirect_pc;
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (pend) q.push_back(pend_pc);
         pend = req;
         if (req) begin
            pend_pc = npc;
            npc     = npc + 13'd1;
         end
      end
   endtask

   always @(posedge clk or posedge reset)
      if (reset) begin
         q.delete();
         pend = 0;
         npc  = '0;
      end else model_edge();

   always @(negedge clk) begin
      logic [12:0] nx;
      if (reset) begin
         check("rst_valid", out_valid, 0);
         check("rst_count", fifo_count, 0);
         check("rst_req", imem_req, 0);
         check("rst_addr", imem_addr, 0);
         check("rst_pc", out_pc, 0);
         check("rst_instr", out_instr, 0);
         check("rst_pc_next", out_pc_next, 1);
      end else begin
         check("count", fifo_count, q.size());
         check("valid", out_valid, q.size() != 0);
         check("req", imem_req, !redirect_valid && (q.size() + int'(pend) < 4));
         check("addr", imem_addr, npc);
         if (q.size() > 0) begin
            nx = q[0] + 13'd1;
            check("pc", out_pc, q[0]);
            check("instr", out_instr, {19'b0, q[0]} + 32'h100);
            check("pc_next", out_pc_next, nx);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (3) step();
      reset = 0;
      step();
      check("first_not_yet", out_valid, 0);
      step();
      for (int k = 0; k < 8; k++) begin
         check("stream_valid", out_valid, 1);
         check("stream_pc", out_pc, k);
         step();
      end
      reset = 1;
      step();
      reset = 0;
      out_ready = 0;
      repeat (10) step();
      check("stall_count", fifo_count, 4);
      check("stall_req", imem_req, 0);
      check("stall_addr", imem_addr, 4);
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", out_valid, 1);
         check("drain_pc", out_pc, k);
         step();
      end
      out_ready = 0;
      for (int i = 0; i < 10 && fifo_count != 3; i++) step();
      check("reach_three", fifo_count, 3);
      redirect_valid = 1;
      redirect_pc = 13'h0A0;
      step();
      redirect_valid = 0;
      out_ready = 1;
      check("redir_flush", out_valid, 0);
      step();
      check("redir_gap", out_valid, 0);
      step();
      check("redir_valid", out_valid, 1);
      check("redir_pc", out_pc, 13'h0A0);
      repeat (3) step();
      redirect_valid = 1;
      redirect_pc = 13'h010;
      step();
      redirect_pc = 13'h020;
      step();
      redirect_valid = 0;
      step();
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_pc", out_pc, 13'h020);
      repeat (3) step();
      redirect_valid = 1;
      redirect_pc = 13'h1FFD;
      step();
      redirect_valid = 0;
      for (int i = 0; i < 10 && !(out_valid && out_pc == 13'h1FFF); i++) step();
      check("wrap_found", out_valid && out_pc == 13'h1FFF, 1);
      check("wrap_pc_next", out_pc_next, 0);
      step();
      check("wrap_valid", out_valid, 1);
      check("wrap_pc", out_pc, 0);
      out_ready = 0;
      repeat (6) step();
      check("full_count", fifo_count, 4);
      reset = 1;
      #1;
      check("async_valid", out_valid, 0);
      check("async_count", fifo_count, 0);
      check("async_req", imem_req, 0);
      step();
      reset = 0;
      out_ready = 1;
      step();
      step();
      check("restart_valid", out_valid, 1);
      check("restart_pc", out_pc, 0);
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
